rr_decoder_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 15 +
 rtl/Decoder_3x8.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_decoder_arbiter.sv | 98 +++++++++
 tb/tb_rr_decoder_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
package arb_pkg;

    localparam int unsigned ARB_N   = 8;
    localparam int unsigned ARB_IDW = 3;

    localparam logic [ARB_IDW-1:0] PTR_RST    = '0;
    localparam logic [ARB_IDW-1:0] GNT_ID_RST = '0;

    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/Decoder_3x8.sv
// 3-to-8 one-hot decoder used to expand the registered grant index.
module Decoder_3x8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_dec
);

    always_comb begin
        o_dec = 8'h00;
        o_dec[i_sel] = 1'b1;
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests to start at i_ptr, take the lowest set bit, un-rotate.
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]   i_req,
    input  logic [ARB_IDW-1:0] i_ptr,
    output logic [ARB_IDW-1:0] o_sel_id,
    output logic               o_any
);

    logic [2*ARB_N-1:0] w_dbl;
    logic [ARB_N-1:0]   w_rot;
    logic [ARB_IDW-1:0] w_off;

    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: ARB_N];

    // Descending scan so the lowest set bit of the rotated vector wins.
    always_comb begin
        w_off = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ARB_IDW'(i);
            end
        end
    end

    assign o_sel_id = i_ptr + w_off;
    assign o_any    = |i_req;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Eight-way round-robin arbiter with hold-until-release grants and a decoded one-hot grant.
// Optional forced revocation after MAX_HOLD cycles is compiled in with ARB_TIMEOUT_EN.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [ARB_N-1:0]   req,
    output logic [ARB_N-1:0]   gnt,
    output logic [ARB_IDW-1:0] gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..15");
    end

    arb_state_e         r_state;
    logic [ARB_IDW-1:0] r_ptr;
    logic [ARB_IDW-1:0] r_gnt_id;
    logic               r_gnt_valid;
    logic [3:0]         r_hold_cnt;
    logic               r_timeout;

    logic [ARB_IDW-1:0] w_sel_id;
    logic               w_any;
    logic [ARB_N-1:0]   w_dec;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
`endif

    rr_pick u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_sel_id (w_sel_id),
        .o_any    (w_any)
    );

    Decoder_3x8 u_dec (
        .i_sel (r_gnt_id),
        .o_dec (w_dec)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= StIdle;
            r_ptr       <= PTR_RST;
            r_gnt_id    <= GNT_ID_RST;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= 4'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_gnt_id    <= w_sel_id;
                        r_hold_cnt  <= 4'd0;
                        r_gnt_valid <= 1'b1;
                        r_state     <= StGrant;
                    end
                end
                StGrant: begin
                    if (!req[r_gnt_id]) begin
                        r_state     <= StIdle;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        // Owner still requesting at its last allowed cycle: revoke.
                        r_state     <= StIdle;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 1'b1;
                        r_timeout   <= 1'b1;
`endif
                    end else if (r_hold_cnt != 4'hF) begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign gnt       = w_dec & {ARB_N{r_gnt_valid}};
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = r_timeout;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter; builds with MAX_HOLD=4 when ARB_TIMEOUT_EN is defined.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       nrst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks;
    int n_pass;

    rr_decoder_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] id;
        n_checks = 0;
        n_pass   = 0;
        nrst     = 1'b0;
        req      = 8'h00;
        #3;
        check("reset_gnt", 32'(gnt), 32'h00);
        check("reset_gnt_id", 32'(gnt_id), 32'd0);
        check("reset_valid", 32'(gnt_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Idle with no requests stays idle.
        step();
        check("idle_valid", 32'(gnt_valid), 32'd0);

        // Single requester 2.
        req = 8'h04;
        step();
        check("single_gnt", 32'(gnt), 32'h04);
        check("single_id", 32'(gnt_id), 32'd2);
        check("single_valid", 32'(gnt_valid), 32'd1);
        req = 8'h00;
        step();
        check("single_release_gnt", 32'(gnt), 32'h00);
        check("single_last_id", 32'(gnt_id), 32'd2);

        // Reset mid-grant: pointer is 3 here, requester 0 wins by wrap.
        req = 8'h01;
        step();
        check("pre_reset_gnt", 32'(gnt), 32'h01);
        step();
        step();
        check("pre_reset_hold", 32'(gnt), 32'h01);
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset_gnt", 32'(gnt), 32'h00);
        check("async_reset_timeout", 32'(timeout), 32'd0);
        check("async_reset_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        req  = 8'hFF;

        // Rotation: all request, each owner drops for one cycle after 2 granted cycles.
        step();
        for (int i = 0; i <= 8; i++) begin
            check($sformatf("rot_id_%0d", i), 32'(gnt_id), 32'(i % 8));
            check($sformatf("rot_gnt_%0d", i), 32'(gnt), 32'(8'h01 << (i % 8)));
            if (i < 8) begin
                step();
                id  = 3'(i);
                req = 8'hFF & ~(8'h01 << id);
                step();
                check($sformatf("rot_gap_%0d", i), 32'(gnt_valid), 32'd0);
                req = 8'hFF;
                step();
            end
        end

        // Wrap-around: steer grant to 7, then release with 0 and 7 requesting.
        req = 8'h80;
        step();
        step();
        check("wrap_pre_id", 32'(gnt_id), 32'd7);
        req = 8'h01;
        step();
        check("wrap_idle", 32'(gnt_valid), 32'd0);
        req = 8'h81;
        step();
        check("wrap_id", 32'(gnt_id), 32'd0);
        check("wrap_gnt", 32'(gnt), 32'h01);

        // No preemption: owner 3 holds while everyone requests.
        req = 8'h08;
        step();
        step();
        check("nopre_start", 32'(gnt), 32'h08);
        req = 8'hFF;
`ifdef ARB_TIMEOUT_EN
        for (int j = 1; j <= 3; j++) begin
            step();
            check($sformatf("nopre_hold_%0d", j), 32'(gnt), 32'h08);
            check($sformatf("nopre_to_%0d", j), 32'(timeout), 32'd0);
        end
        step();
        check("revoke_gnt", 32'(gnt), 32'h00);
        check("revoke_timeout", 32'(timeout), 32'd1);
        step();
        check("revoke_pulse_end", 32'(timeout), 32'd0);
        check("revoke_next_id", 32'(gnt_id), 32'd4);
        check("revoke_next_gnt", 32'(gnt), 32'h10);
`else
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("nopre_hold_%0d", j), 32'(gnt), 32'h08);
            check($sformatf("nopre_to_%0d", j), 32'(timeout), 32'd0);
        end
        req = 8'hF7;
        step();
        check("nopre_release", 32'(gnt_valid), 32'd0);
        step();
        check("nopre_next_id", 32'(gnt_id), 32'd4);
        check("nopre_next_gnt", 32'(gnt), 32'h10);
`endif

        req = 8'h00;
        step();
        step();
        check("final_idle", 32'(gnt), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
